// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, FSM encoding, field layout.
package cpu_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpShl  = 4'h6,
    OpShr  = 4'h7,
    OpLdi  = 4'h8,
    OpLd   = 4'h9,
    OpSt   = 4'hA,
    OpIn   = 4'hB,
    OpOut  = 4'hC,
    OpBeq  = 4'hD,
    OpJmp  = 4'hE,
    OpHalt = 4'hF
  } op_e;

  localparam logic [2:0] ST_LOAD     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_EXEC     = 3'd2;
  localparam logic [2:0] ST_MEM_WAIT = 3'd3;
  localparam logic [2:0] ST_IO_WAIT  = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;

  localparam int unsigned IRQ_VEC_DEFAULT = 1;

  // Instruction layout, msb to lsb: op(4) | rd | rs0 | rs1
  function automatic int unsigned ins_bits(input int unsigned szb_reg);
    return 4 + 3 * szb_reg;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned szb_reg);
    return 2 * szb_reg;
  endfunction

  function automatic int unsigned rs0_lsb(input int unsigned szb_reg);
    return szb_reg;
  endfunction

endpackage

// File: rtl/cpu_regfile_mc.sv
// Data register file: two asynchronous read ports, one synchronous write port.
module cpu_regfile_mc
  import cpu_pkg::*;
#(
  parameter int unsigned BIT_DATA = 8,
  parameter int unsigned SZB_REG  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SZB_REG-1:0]  raddr_a,
  input  logic [SZB_REG-1:0]  raddr_b,
  output logic [BIT_DATA-1:0] rdata_a,
  output logic [BIT_DATA-1:0] rdata_b,
  input  logic                we,
  input  logic [SZB_REG-1:0]  waddr,
  input  logic [BIT_DATA-1:0] wdata
);

  logic [BIT_DATA-1:0] regs_q [2**SZB_REG];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**SZB_REG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core with RAM/IO valid-ack handshakes and a program-load port.
// Optional interrupt support is enabled by defining CPU_CORE_IRQ_EN.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int unsigned BIT_DATA = 8,
  parameter int unsigned SZB_REG  = 4,
  parameter int unsigned SZB_INS  = 6,
  parameter int unsigned SZB_RAM  = 8
`ifdef CPU_CORE_IRQ_EN
  ,
  parameter int unsigned IRQ_VEC  = IRQ_VEC_DEFAULT
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef CPU_CORE_IRQ_EN
  input  logic                   irq,
`endif
  input  logic                   prog_mode,
  input  logic                   prog_we,
  input  logic [SZB_INS-1:0]     prog_addr,
  input  logic [4+3*SZB_REG-1:0] prog_data,
  input  logic [BIT_DATA-1:0]    io_din,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  output logic [BIT_DATA-1:0]    io_dout,
  output logic                   io_out_valid,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [SZB_RAM-1:0]     ram_addr,
  output logic [BIT_DATA-1:0]    ram_d,
  input  logic                   ram_ack,
  input  logic [BIT_DATA-1:0]    ram_q,
  output logic                   halted,
  output logic [SZB_INS-1:0]     pc_out
);

  localparam int unsigned BIT_INS = ins_bits(SZB_REG);
  localparam int unsigned RD_LSB  = rd_lsb(SZB_REG);
  localparam int unsigned RS0_LSB = rs0_lsb(SZB_REG);

  logic [BIT_INS-1:0]  imem [2**SZB_INS];

  logic [2:0]          state_q, state_d;
  logic [SZB_INS-1:0]  pc_q, pc_d, ir_pc_q, ir_pc_d;
  logic [BIT_INS-1:0]  ir_q, ir_d;
  logic [BIT_DATA-1:0] io_dout_q, io_dout_d;
  logic                io_out_valid_q, io_out_valid_d;
  logic                ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [SZB_RAM-1:0]  ram_addr_q, ram_addr_d;
  logic [BIT_DATA-1:0] ram_d_q, ram_d_d;
`ifdef CPU_CORE_IRQ_EN
  logic [SZB_INS-1:0]  epc_q, epc_d;
  logic                in_service_q, in_service_d;
`endif

  op_e                 op;
  logic [SZB_REG-1:0]  rd, rs0, rs1;
  logic [2*SZB_REG-1:0] imm;
  logic [SZB_INS-1:0]  off_ext;
  logic                is_beq;

  logic [SZB_REG-1:0]  raddr_a, raddr_b;
  logic [BIT_DATA-1:0] rdata_a, rdata_b;
  logic                rf_we;
  logic [BIT_DATA-1:0] rf_wdata, alu_y;

  assign op      = op_e'(ir_q[BIT_INS-1 -: 4]);
  assign rd      = ir_q[RD_LSB +: SZB_REG];
  assign rs0     = ir_q[RS0_LSB +: SZB_REG];
  assign rs1     = ir_q[0 +: SZB_REG];
  assign imm     = {rs0, rs1};
  assign off_ext = {{(SZB_INS-SZB_REG){rs1[SZB_REG-1]}}, rs1};

  // BEQ compares R[rd] with R[rs0], so the read ports shift by one field.
  assign is_beq  = (op == OpBeq);
  assign raddr_a = is_beq ? rd  : rs0;
  assign raddr_b = is_beq ? rs0 : rs1;

  cpu_regfile_mc #(
    .BIT_DATA(BIT_DATA),
    .SZB_REG (SZB_REG)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .raddr_a(raddr_a),
    .raddr_b(raddr_b),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata)
  );

  always_comb begin
    alu_y = '0;
    case (op)
      OpAdd:   alu_y = rdata_a + rdata_b;
      OpSub:   alu_y = rdata_a - rdata_b;
      OpAnd:   alu_y = rdata_a & rdata_b;
      OpOr:    alu_y = rdata_a | rdata_b;
      OpXor:   alu_y = rdata_a ^ rdata_b;
      OpShl:   alu_y = rdata_a << 1;
      OpShr:   alu_y = rdata_a >> 1;
      OpLdi:   alu_y = BIT_DATA'(imm);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    ir_pc_d        = ir_pc_q;
    io_dout_d      = io_dout_q;
    io_out_valid_d = 1'b0;
    ram_req_d      = ram_req_q;
    ram_we_d       = ram_we_q;
    ram_addr_d     = ram_addr_q;
    ram_d_d        = ram_d_q;
    rf_we          = 1'b0;
    rf_wdata       = alu_y;
    io_in_ready    = 1'b0;
`ifdef CPU_CORE_IRQ_EN
    epc_d          = epc_q;
    in_service_d   = in_service_q;
`endif
    case (state_q)
      ST_FETCH: begin
        if (prog_mode) begin
          state_d = ST_LOAD;
        end
`ifdef CPU_CORE_IRQ_EN
        else if (irq && !in_service_q) begin
          // Redirect only; the vector is fetched on the next cycle.
          epc_d        = pc_q;
          pc_d         = SZB_INS'(IRQ_VEC);
          in_service_d = 1'b1;
        end
`endif
        else begin
          ir_d    = imem[pc_q];
          ir_pc_d = pc_q;
          pc_d    = pc_q + SZB_INS'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        unique case (op)
          OpNop: begin
`ifdef CPU_CORE_IRQ_EN
            if (rd == SZB_REG'(1)) begin
              pc_d         = epc_q;
              in_service_d = 1'b0;
            end
`endif
          end
          OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr, OpLdi: rf_we = 1'b1;
          OpLd: begin
            ram_req_d  = 1'b1;
            ram_we_d   = 1'b0;
            ram_addr_d = SZB_RAM'(rdata_a);
            state_d    = ST_MEM_WAIT;
          end
          OpSt: begin
            ram_req_d  = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = SZB_RAM'(rdata_a);
            ram_d_d    = rdata_b;
            state_d    = ST_MEM_WAIT;
          end
          OpIn:  state_d = ST_IO_WAIT;
          OpOut: begin
            io_dout_d      = rdata_a;
            io_out_valid_d = 1'b1;
          end
          OpBeq: begin
            if (rdata_a == rdata_b) pc_d = ir_pc_q + off_ext;
          end
          OpJmp:  pc_d    = SZB_INS'(imm);
          OpHalt: state_d = ST_HALT;
        endcase
      end
      ST_MEM_WAIT: begin
        if (ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = ST_FETCH;
          if (!ram_we_q) begin
            rf_we    = 1'b1;
            rf_wdata = ram_q;
          end
        end
      end
      ST_IO_WAIT: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          rf_we    = 1'b1;
          rf_wdata = io_din;
          state_d  = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (prog_mode) begin
          state_d = ST_LOAD;
        end
`ifdef CPU_CORE_IRQ_EN
        else if (irq && !in_service_q) begin
          epc_d        = pc_q;
          pc_d         = SZB_INS'(IRQ_VEC);
          in_service_d = 1'b1;
          state_d      = ST_FETCH;
        end
`endif
      end
      ST_LOAD: begin
        if (!prog_mode) begin
          pc_d    = '0;
          state_d = ST_FETCH;
`ifdef CPU_CORE_IRQ_EN
          in_service_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_FETCH;
      pc_q           <= '0;
      ir_q           <= '0;
      ir_pc_q        <= '0;
      io_dout_q      <= '0;
      io_out_valid_q <= 1'b0;
      ram_req_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_d_q        <= '0;
`ifdef CPU_CORE_IRQ_EN
      epc_q          <= '0;
      in_service_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      ir_pc_q        <= ir_pc_d;
      io_dout_q      <= io_dout_d;
      io_out_valid_q <= io_out_valid_d;
      ram_req_q      <= ram_req_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_d_q        <= ram_d_d;
`ifdef CPU_CORE_IRQ_EN
      epc_q          <= epc_d;
      in_service_q   <= in_service_d;
`endif
    end
  end

  // Instruction store survives reset so a program can rerun after it.
  always_ff @(posedge clock) begin
    if (state_q == ST_LOAD && prog_we) begin
      imem[prog_addr] <= prog_data;
    end
  end

  assign io_dout      = io_dout_q;
  assign io_out_valid = io_out_valid_q;
  assign ram_req      = ram_req_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_d        = ram_d_q;
  assign halted       = (state_q == ST_HALT) || (state_q == ST_LOAD);
  assign pc_out       = pc_q;

endmodule
